// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2StateT;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  // E1 (Pause) looks like an extension prefix but is reported as an ordinary code.
  function automatic logic isPrefix(input logic [7:0] b);
    return (b != PS2_PAUSE) && ((b == PS2_EXT) || (b == PS2_REL));
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser plus equality filter for one PS/2 line, with a
// one-cycle falling-edge pulse on the filtered value.
module ps2_filter #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic filtered,
  output logic fall
);

  localparam int CW = $clog2(FILTER);

  logic [1:0]    sync;
  logic [CW-1:0] runCnt;
  logic          filteredQ;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values; blocking assignments would collapse the synchroniser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync      <= 2'b11;
      runCnt    <= '0;
      filtered  <= 1'b1;
      filteredQ <= 1'b1;
    end else begin
      sync      <= {sync[0], line};
      filteredQ <= filtered;
      if (sync[1] == filtered) begin
        runCnt <= '0;
      end else if (runCnt == CW'(FILTER - 1)) begin
        filtered <= sync[1];
        runCnt   <= '0;
      end else begin
        runCnt <= runCnt + 1'b1;
      end
    end
  end

  assign fall = filteredQ & ~filtered;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames and folds E0/F0
// prefixes into ext/rel flags. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strb,
  output logic [7:0] code,
  output logic       ext,
  output logic       rel,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT);

  ps2StateT      state, nextState;
  logic          ckFall, dFilt;
  logic          unusedCkLevel, unusedDataFall;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic [TW-1:0] timer;
  logic          extFlag, relFlag;
  logic          timeoutHit, frameDone, frameValid;
  logic          strbNext, errNext, setExt, setRel;

  ps2_filter #(.FILTER(FILTER)) ckFilter (
    .clock    (clock),
    .reset    (reset),
    .line     (ps2Ck),
    .filtered (unusedCkLevel),
    .fall     (ckFall)
  );

  ps2_filter #(.FILTER(FILTER)) dFilter (
    .clock    (clock),
    .reset    (reset),
    .line     (ps2D),
    .filtered (dFilt),
    .fall     (unusedDataFall)
  );

  // A fall in the terminal-count cycle wins over the timeout.
  assign timeoutHit = (state != IDLE) && (timer == TW'(TIMEOUT - 1)) && !ckFall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    if (timeoutHit) begin
      nextState = IDLE;
    end else if (ckFall) begin
      case (state)
        IDLE:    if (!dFilt) nextState = DATA;
        DATA:    if (bitCnt == 3'(PS2_DATA_BITS - 1)) nextState = PARITY;
        PARITY:  nextState = STOP;
        STOP:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frameValid = dFilt && (^{shiftReg, parityBit});
`else
  logic unusedParity;
  assign unusedParity = parityBit;
  assign frameValid   = dFilt;
`endif

  always_comb begin
    frameDone = ckFall && (state == STOP);
    strbNext  = frameDone && frameValid && !isPrefix(shiftReg);
    errNext   = (frameDone && !frameValid) || timeoutHit;
    setExt    = frameDone && frameValid && (shiftReg == PS2_EXT);
    setRel    = frameDone && frameValid && (shiftReg == PS2_REL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strb      <= 1'b0;
      err       <= 1'b0;
      code      <= 8'h00;
      ext       <= 1'b0;
      rel       <= 1'b0;
      extFlag   <= 1'b0;
      relFlag   <= 1'b0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      timer     <= '0;
    end else begin
      strb <= strbNext;
      err  <= errNext;
      if (strbNext) begin
        code <= shiftReg;
        ext  <= extFlag;
        rel  <= relFlag;
      end

      if (strbNext || errNext) begin
        extFlag <= 1'b0;
        relFlag <= 1'b0;
      end else begin
        if (setExt) extFlag <= 1'b1;
        if (setRel) relFlag <= 1'b1;
      end

      if (ckFall) begin
        case (state)
          IDLE:   bitCnt <= '0;
          DATA: begin
            shiftReg[bitCnt] <= dFilt;
            bitCnt           <= bitCnt + 1'b1;
          end
          PARITY: parityBit <= dFilt;
          default: ;
        endcase
      end

      if (ckFall || (state == IDLE))    timer <= '0;
      else if (timer != TW'(TIMEOUT - 1)) timer <= timer + 1'b1;
    end
  end

endmodule
